// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg: segment patterns, digit count and digit-index type shared by the scan driver.
package bcd_seg_pkg;
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam int NUM_DIGITS = 3;
    typedef logic [1:0] idx_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low {g,f,e,d,c,b,a} pattern; invalid BCD shows a dash.
module seg7_decode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: 3-digit multiplexed common-anode scan driver with frame-synchronous shadow load.
// Define SEG_LZB_EN to enable leading-zero blanking of the hundreds and tens digits.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);
    localparam idx_t TOP = idx_t'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    idx_t          idx;
    logic [11:0]   shadow;
    logic [3:0]    nib;
    logic [6:0]    pat;
    logic          last, load, sup, off;

    assign last = cnt == LAST;
    assign load = last && idx == TOP;
    assign nib  = idx == 2'd2 ? shadow[11:8] : idx == 2'd1 ? shadow[7:4] : shadow[3:0];

`ifdef SEG_LZB_EN
    // Only true zeros are suppressed, so dashes for invalid nibbles always show.
    assign sup = (idx == 2'd2 && shadow[11:8] == 4'd0) ||
                 (idx == 2'd1 && shadow[11:4] == 8'd0);
`else
    assign sup = 1'b0;
`endif

    assign off = cnt < BLANK || sup;

    seg7_decode u_dec (
        .nib (nib),
        .seg (pat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            seg        <= SEG_OFF;
            an         <= 3'b111;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= last ? '0 : cnt + 1'b1;
            if (last)
                idx <= idx == TOP ? '0 : idx + 1'b1;
            if (load)
                shadow <= bcd_in;
            frame_tick <= load;
            seg        <= off ? SEG_OFF : pat;
            an         <= off ? 3'b111 : ~(3'b001 << idx);
        end
    end
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: table-driven check of the scan driver with SCAN_DIV=8, BLANK_CYC=2.
module tb_bcd_seg_scan;
    localparam int SD = 8;
    localparam int BC = 2;
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct packed {
        logic [11:0]     bcd;
        logic [2:0][6:0] s;
        logic [2:0]      off;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd_in = 12'h000;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_tick;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;

    bcd_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = frame_tick === 1'b1;
        end
        chk("tick_seen", {15'd0, seen}, 16'd1);
    endtask

    // Called on the negedge where frame_tick is high; checks the following 24 slot cycles.
    task automatic check_frame(input vec_t v, input logic [11:0] mid, input bit do_mid);
        int slot, c;
        logic [2:0] ea;
        logic [6:0] es;
        for (int k = 1; k <= 3 * SD; k++) begin
            @(negedge clk);
            slot = (k - 1) / SD;
            c    = (k - 1) % SD;
            ea   = (c < BC || v.off[slot]) ? 3'b111 : ~(3'b001 << slot);
            es   = (c < BC || v.off[slot]) ? 7'h7F : v.s[slot];
            chk($sformatf("frame_%03h_k%0d", v.bcd, k), {6'd0, ea !== an ? an : ea, seg}, {6'd0, ea, es});
            if (do_mid && k == 12)
                bcd_in = mid;
        end
    endtask

    vec_t vecs [7];
    vec_t v123, v456;
    int   tk [5];

    initial begin
        vecs[0] = '{bcd: 12'h259, s: {7'h24, 7'h12, 7'h10}, off: 3'b000};
        vecs[1] = '{bcd: 12'h0A5, s: {7'h40, 7'h3F, 7'h12}, off: LZB ? 3'b100 : 3'b000};
        vecs[2] = '{bcd: 12'h007, s: {7'h40, 7'h40, 7'h78}, off: LZB ? 3'b110 : 3'b000};
        vecs[3] = '{bcd: 12'h000, s: {7'h40, 7'h40, 7'h40}, off: LZB ? 3'b110 : 3'b000};
        vecs[4] = '{bcd: 12'h808, s: {7'h00, 7'h40, 7'h00}, off: 3'b000};
        vecs[5] = '{bcd: 12'hFFF, s: {7'h3F, 7'h3F, 7'h3F}, off: 3'b000};
        vecs[6] = '{bcd: 12'h0C0, s: {7'h40, 7'h3F, 7'h40}, off: LZB ? 3'b100 : 3'b000};
        v123    = '{bcd: 12'h123, s: {7'h79, 7'h24, 7'h30}, off: 3'b000};
        v456    = '{bcd: 12'h456, s: {7'h19, 7'h12, 7'h02}, off: 3'b000};

        #1 rst = 1'b0;
        #2;
        chk("rst_seg", {9'd0, seg}, 16'h007F);
        chk("rst_an", {13'd0, an}, 16'h0007);
        chk("rst_tick", {15'd0, frame_tick}, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bcd_in = vecs[i].bcd;
            wait_tick();
            check_frame(vecs[i], 12'h000, 1'b0);
        end

        bcd_in = 12'h123;
        wait_tick();
        check_frame(v123, 12'h456, 1'b1);
        wait_tick();
        check_frame(v456, 12'h000, 1'b0);

        for (int i = 0; i < 5; i++) begin
            wait_tick();
            tk[i] = cyc;
            @(negedge clk);
            chk("tick_width", {15'd0, frame_tick}, 16'd0);
            if (i > 0)
                chk("tick_period", 16'(tk[i] - tk[i-1]), 16'(3 * SD));
        end

        bcd_in = 12'h888;
        wait_tick();
        repeat (12) @(negedge clk);
        chk("pre_rst_an", {13'd0, an}, 16'h0005);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_seg", {9'd0, seg}, 16'h007F);
        chk("mid_rst_an", {13'd0, an}, 16'h0007);
        chk("mid_rst_tick", {15'd0, frame_tick}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= SD; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_k%0d", k), {6'd0, an, seg},
                k <= BC ? {6'd0, 3'b111, 7'h7F} : {6'd0, 3'b110, 7'h40});
            chk("post_rst_tick", {15'd0, frame_tick}, 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
